// File: rtl/pwm_multichannel_pkg.sv
// Shared definitions for the multi-channel PWM generator.
// Holds the mode and counter-direction encodings, the default widths shared
// with the I/O register decoder, and a helper that sizes the channel-index port.
package pwm_multichannel_pkg;

  // Output alignment mode, latched once per period boundary.
  typedef enum logic {
    PWM_MODE_EDGE   = 1'b0,
    PWM_MODE_CENTER = 1'b1
  } pwm_mode_e;

  // Period counter direction; only center-aligned mode ever counts down.
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } cnt_dir_e;

  localparam int DEF_NUM_CH        = 4;
  localparam int DEF_PWM_BIT_WIDTH = 8;
  localparam int DEF_PRESCALE_BITS = 12;

  // Width of a channel index: max(1, clog2(n)).
  function automatic int ch_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Tick generator: emits a one-clock tick every prescale_i+1 clocks while run_i
// is high. Kept separate so other timers can reuse it.
//   clk_i      : clock
//   reset_i    : synchronous active-high reset
//   run_i      : count enable; when low the counter is held at 0
//   prescale_i : terminal count (tick every prescale_i+1 clocks)
//   tick_o     : combinational tick, high in the cycle the count reaches top
module pwm_prescaler
  import pwm_multichannel_pkg::*;
#(
  parameter int PRESCALE_BITS = DEF_PRESCALE_BITS
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     run_i,
  input  logic [PRESCALE_BITS-1:0] prescale_i,
  output logic                     tick_o
);

  logic [PRESCALE_BITS-1:0] pcnt_q, pcnt_d;

  // >= rather than == so that lowering prescale below the current count
  // terminates the interval immediately instead of wrapping the full range.
  always_comb begin
    tick_o = run_i && (pcnt_q >= prescale_i);
    pcnt_d = pcnt_q + PRESCALE_BITS'(1);
    if (!run_i || tick_o) begin
      pcnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/pwm_multichannel.sv
// Multi-channel PWM generator with one shared prescaler and period counter.
// Duty values are double-buffered (shadow -> active at each period boundary) so
// outputs never glitch mid-period. Supports edge- and center-aligned modes.
//   clk          : clock
//   reset        : synchronous active-high reset
//   en           : run enable; low holds the counter at 0 and outputs low
//   prescale     : counter advances every prescale+1 clocks
//   period       : counter top value, used live
//   center_mode  : 0 edge-aligned, 1 center-aligned; sampled at boundaries
//   wr_en/wr_ch/wr_duty : write a pending duty into a channel's shadow
//   pwm_out      : registered PWM outputs, one per channel
//   period_start : one-clock pulse marking the first count of each period
module pwm_multichannel
  import pwm_multichannel_pkg::*;
#(
  parameter int NUM_CH        = DEF_NUM_CH,
  parameter int PWM_BIT_WIDTH = DEF_PWM_BIT_WIDTH,
  parameter int PRESCALE_BITS = DEF_PRESCALE_BITS
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              en,
  input  logic [PRESCALE_BITS-1:0]          prescale,
  input  logic [PWM_BIT_WIDTH-1:0]          period,
  input  logic                              center_mode,
  input  logic                              wr_en,
  input  logic [ch_idx_width(NUM_CH)-1:0]   wr_ch,
  input  logic [PWM_BIT_WIDTH-1:0]          wr_duty,
  output logic [NUM_CH-1:0]                 pwm_out,
  output logic                              period_start
);

  localparam int CH_W = ch_idx_width(NUM_CH);
  localparam logic [PWM_BIT_WIDTH-1:0] ONE = PWM_BIT_WIDTH'(1);

  logic                     en_q;
  logic                     run;
  logic                     start;
  logic                     tick;
  logic                     wrap;
  logic                     bnd;
  logic [PWM_BIT_WIDTH-1:0] cnt_q, cnt_d;
  cnt_dir_e                 dir_q, dir_d;
  pwm_mode_e                mode_q, mode_d;
  logic                     frame_q;
  logic                     period_start_q;

  // The first enabled cycle is a "start" cycle: it acts as a period boundary
  // at cnt=0 without advancing, so the first frame looks like any other.
  assign run   = en && en_q;
  assign start = en && !en_q;

  pwm_prescaler #(
    .PRESCALE_BITS(PRESCALE_BITS)
  ) u_prescaler (
    .clk_i     (clk),
    .reset_i   (reset),
    .run_i     (run),
    .prescale_i(prescale),
    .tick_o    (tick)
  );

  // Period counter next state
  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    wrap  = 1'b0;
    if (!en || start) begin
      cnt_d = '0;
      dir_d = DIR_UP;
    end else if (tick) begin
      if (mode_q == PWM_MODE_EDGE) begin
        if (cnt_q >= period) begin
          cnt_d = '0;
          wrap  = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end else if (dir_q == DIR_UP) begin
        if (cnt_q >= period) begin
          // Turning around at 0 or 1 would land straight on 0, so that is
          // the frame end itself (covers period 0 and 1 without an extra 0).
          if (cnt_q <= ONE) begin
            cnt_d = '0;
            wrap  = 1'b1;
          end else begin
            cnt_d = cnt_q - ONE;
            dir_d = DIR_DOWN;
          end
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end else begin
        if (cnt_q <= ONE) begin
          cnt_d = '0;
          dir_d = DIR_UP;
          wrap  = 1'b1;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
    end
  end

  assign bnd    = start || wrap;
  assign mode_d = bnd ? pwm_mode_e'(center_mode) : mode_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      en_q           <= 1'b0;
      cnt_q          <= '0;
      dir_q          <= DIR_UP;
      mode_q         <= PWM_MODE_EDGE;
      frame_q        <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      en_q           <= en;
      cnt_q          <= cnt_d;
      dir_q          <= dir_d;
      mode_q         <= mode_d;
      frame_q        <= bnd;
      period_start_q <= frame_q && en;
    end
  end

  assign period_start = period_start_q;

  // Per-channel duty buffering and compare
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [PWM_BIT_WIDTH-1:0] shadow_q;
    logic [PWM_BIT_WIDTH-1:0] active_q;
    logic                     pwm_q;
    logic                     wr_sel;

    // Out-of-range indices match no channel and are dropped.
    assign wr_sel = wr_en && (wr_ch == CH_W'(i));

    always_ff @(posedge clk) begin
      if (reset) begin
        shadow_q <= '0;
        active_q <= '0;
        pwm_q    <= 1'b0;
      end else begin
        if (wr_sel) begin
          shadow_q <= wr_duty;
        end
        if (!en || bnd) begin
          active_q <= shadow_q;
        end
        pwm_q <= run && (active_q > cnt_q);
      end
    end

    assign pwm_out[i] = pwm_q;
  end

endmodule

// File: tb/tb_pwm_multichannel.sv
module tb_pwm_multichannel;

  // Five channels so a 3-bit channel index can address non-existent channels.
  localparam int NCH = 5;
  localparam int W   = 8;
  localparam int PB  = 12;
  localparam int CHW = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic           en;
  logic [PB-1:0]  prescale;
  logic [W-1:0]   period;
  logic           center_mode;
  logic           wr_en;
  logic [CHW-1:0] wr_ch;
  logic [W-1:0]   wr_duty;
  logic [NCH-1:0] pwm_out;
  logic           period_start;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pwm_multichannel #(
    .NUM_CH(NCH),
    .PWM_BIT_WIDTH(W),
    .PRESCALE_BITS(PB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .prescale    (prescale),
    .period      (period),
    .center_mode (center_mode),
    .wr_en       (wr_en),
    .wr_ch       (wr_ch),
    .wr_duty     (wr_duty),
    .pwm_out     (pwm_out),
    .period_start(period_start)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input int duty);
    wr_en   = 1'b1;
    wr_ch   = CHW'(ch);
    wr_duty = W'(duty);
    step();
    wr_en   = 1'b0;
  endtask

  task automatic init(input int psc, input int per, input logic cm);
    reset       = 1'b1;
    en          = 1'b0;
    wr_en       = 1'b0;
    wr_ch       = '0;
    wr_duty     = '0;
    prescale    = PB'(psc);
    period      = W'(per);
    center_mode = cm;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    init(0, 9, 1'b0);
    reset   = 1'b1;
    en      = 1'b1;
    wr_en   = 1'b1;
    wr_ch   = 3'd0;
    wr_duty = 8'd200;
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if (pwm_out !== 5'b00000 || period_start !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold k=%0d pwm_out=%b exp=00000 ps=%b exp=0", k, pwm_out, period_start);
      end
    end
    reset = 1'b0;
    en    = 1'b0;
    wr_en = 1'b0;
    step();
    total++;
    if (pwm_out !== 5'b00000 || period_start !== 1'b0) begin
      bad++;
      $display("FAIL reset_release pwm_out=%b exp=00000 ps=%b exp=0", pwm_out, period_start);
    end
    en = 1'b1;
    step();
    step();
    total++;
    if (pwm_out !== 5'b00000 || period_start !== 1'b1) begin
      bad++;
      $display("FAIL reset_cleared_duty pwm_out=%b exp=00000 ps=%b exp=1", pwm_out, period_start);
    end
  endtask

  task automatic test_edge_duty();
    logic [NCH-1:0] ep;
    logic           eps;
    init(0, 9, 1'b0);
    wr(0, 3);
    en = 1'b1;
    step();
    total++;
    if (pwm_out !== 5'b00000 || period_start !== 1'b0) begin
      bad++;
      $display("FAIL edge_start_idle pwm_out=%b exp=00000 ps=%b exp=0", pwm_out, period_start);
    end
    step();
    for (int k = 0; k < 30; k++) begin
      ep    = '0;
      ep[0] = (k % 10) < 3;
      eps   = (k % 10) == 0;
      total++;
      if (pwm_out !== ep || period_start !== eps) begin
        bad++;
        $display("FAIL edge_duty k=%0d pwm_out=%b exp=%b ps=%b exp=%b", k, pwm_out, ep, period_start, eps);
      end
      step();
    end
  endtask

  task automatic test_double_buffer();
    logic [NCH-1:0] ep;
    logic           eps;
    init(0, 9, 1'b0);
    wr(1, 2);
    en = 1'b1;
    step();
    step();
    for (int k = 0; k < 20; k++) begin
      ep    = '0;
      ep[1] = (k < 10) ? (k < 2) : ((k - 10) < 7);
      eps   = (k % 10) == 0;
      total++;
      if (pwm_out !== ep || period_start !== eps) begin
        bad++;
        $display("FAIL double_buffer k=%0d pwm_out=%b exp=%b ps=%b exp=%b", k, pwm_out, ep, period_start, eps);
      end
      if (k == 3) begin
        wr_en   = 1'b1;
        wr_ch   = 3'd1;
        wr_duty = 8'd7;
      end else begin
        wr_en = 1'b0;
      end
      step();
    end
    wr_en = 1'b0;
  endtask

  task automatic test_center();
    logic [NCH-1:0] ep;
    logic           eps;
    int             m;
    init(0, 4, 1'b1);
    wr(2, 2);
    en = 1'b1;
    step();
    step();
    for (int k = 0; k < 24; k++) begin
      m     = k % 8;
      ep    = '0;
      ep[2] = (m < 2) || (m == 7);
      eps   = (m == 0);
      total++;
      if (pwm_out !== ep || period_start !== eps) begin
        bad++;
        $display("FAIL center k=%0d pwm_out=%b exp=%b ps=%b exp=%b", k, pwm_out, ep, period_start, eps);
      end
      step();
    end
  endtask

  task automatic test_extremes();
    logic eps;
    init(0, 9, 1'b0);
    wr(3, 0);
    wr(4, 255);
    en = 1'b1;
    step();
    step();
    for (int k = 0; k < 30; k++) begin
      eps = (k % 10) == 0;
      total++;
      if (pwm_out !== 5'b10000 || period_start !== eps) begin
        bad++;
        $display("FAIL extremes k=%0d pwm_out=%b exp=10000 ps=%b exp=%b", k, pwm_out, period_start, eps);
      end
      step();
    end
  endtask

  task automatic test_prescaler_badch();
    logic [NCH-1:0] ep;
    logic           eps;
    int             m;
    init(3, 1, 1'b0);
    wr(0, 1);
    wr(5, 255);
    wr(7, 200);
    en = 1'b1;
    step();
    step();
    for (int k = 0; k < 24; k++) begin
      m   = k % 8;
      ep  = (m < 4) ? 5'b00001 : 5'b00000;
      eps = (m == 0);
      total++;
      if (pwm_out !== ep || period_start !== eps) begin
        bad++;
        $display("FAIL prescale_badch k=%0d pwm_out=%b exp=%b ps=%b exp=%b", k, pwm_out, ep, period_start, eps);
      end
      if (k == 3) begin
        wr_en   = 1'b1;
        wr_ch   = 3'd6;
        wr_duty = 8'd255;
      end else begin
        wr_en = 1'b0;
      end
      step();
    end
    wr_en = 1'b0;
  endtask

  task automatic test_reset_disable();
    logic [NCH-1:0] ep;
    logic           eps;
    init(0, 9, 1'b0);
    wr(0, 6);
    wr(1, 9);
    en = 1'b1;
    step();
    step();
    step();
    step();
    step();
    step();
    total++;
    if (pwm_out !== 5'b00011 || period_start !== 1'b0) begin
      bad++;
      $display("FAIL pre_reset pwm_out=%b exp=00011 ps=%b exp=0", pwm_out, period_start);
    end
    reset = 1'b1;
    step();
    total++;
    if (pwm_out !== 5'b00000 || period_start !== 1'b0) begin
      bad++;
      $display("FAIL midframe_reset pwm_out=%b exp=00000 ps=%b exp=0", pwm_out, period_start);
    end
    reset = 1'b0;
    step();
    step();
    for (int k = 0; k < 13; k++) begin
      ep    = '0;
      ep[3] = (k >= 10) && ((k - 10) < 9);
      eps   = (k % 10) == 0;
      total++;
      if (pwm_out !== ep || period_start !== eps) begin
        bad++;
        $display("FAIL after_reset k=%0d pwm_out=%b exp=%b ps=%b exp=%b", k, pwm_out, ep, period_start, eps);
      end
      if (k == 2) begin
        wr_en   = 1'b1;
        wr_ch   = 3'd3;
        wr_duty = 8'd9;
      end else begin
        wr_en = 1'b0;
      end
      if (k < 12) step();
    end
    wr_en = 1'b0;
    en    = 1'b0;
    step();
    for (int k = 0; k < 6; k++) begin
      total++;
      if (pwm_out !== 5'b00000 || period_start !== 1'b0) begin
        bad++;
        $display("FAIL disabled k=%0d pwm_out=%b exp=00000 ps=%b exp=0", k, pwm_out, period_start);
      end
      if (k == 1) begin
        wr_en   = 1'b1;
        wr_ch   = 3'd2;
        wr_duty = 8'd5;
      end else begin
        wr_en = 1'b0;
      end
      step();
    end
    wr_en = 1'b0;
    en    = 1'b1;
    step();
    total++;
    if (pwm_out !== 5'b00000 || period_start !== 1'b0) begin
      bad++;
      $display("FAIL reenable_idle pwm_out=%b exp=00000 ps=%b exp=0", pwm_out, period_start);
    end
    step();
    for (int k = 0; k < 10; k++) begin
      ep    = '0;
      ep[2] = k < 5;
      ep[3] = k < 9;
      eps   = (k == 0);
      total++;
      if (pwm_out !== ep || period_start !== eps) begin
        bad++;
        $display("FAIL reenable_frame k=%0d pwm_out=%b exp=%b ps=%b exp=%b", k, pwm_out, ep, period_start, eps);
      end
      step();
    end
  endtask

  initial begin
    reset       = 1'b1;
    en          = 1'b0;
    prescale    = '0;
    period      = '0;
    center_mode = 1'b0;
    wr_en       = 1'b0;
    wr_ch       = '0;
    wr_duty     = '0;
    test_reset();
    test_edge_duty();
    test_double_buffer();
    test_center();
    test_extremes();
    test_prescaler_badch();
    test_reset_disable();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
